// File: rtl/tsn_wcc_packer.sv
// tsn_wcc_packer: turns header+data packets from a FWFT FIFO into per-beat write commands
//   fpu_clk, reset      clock, asynchronous active-high reset
//   ff_rd_data/ff_empty FIFO head word and empty flag; ff_rd_en pops one word
//   wcc_*               registered write command, valid/ready handshake
//   pkt_done            pulse when a good packet completes
//   bad_pkt_cnt         saturating count of dropped packets; busy = not IDLE
module tsn_wcc_packer #(
    parameter logic [7:0]  OPCODE_WR   = 8'h01,
    parameter int          ADDR_STRIDE = 16,
    parameter logic [15:0] MAX_LEN     = 16'd1024
) (
    input  logic         fpu_clk,
    input  logic         reset,
    input  logic [127:0] ff_rd_data,
    input  logic         ff_empty,
    output logic         ff_rd_en,
    output logic [39:0]  wcc_dram_addr,
    output logic [15:0]  wcc_dpram_addr,
    output logic [15:0]  wcc_length,
    output logic [127:0] wcc_write_data,
    output logic         wcc_valid,
    input  logic         wcc_ready,
    output logic         pkt_done,
    output logic [7:0]   bad_pkt_cnt,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, CHK, DATA, DROP} state_t;
    state_t state, state_nxt;
    logic [39:0] dram_base;
    logic [15:0] dpram_base, len, pop_cnt;
    logic [7:0]  opcode;
    logic        load, accept, bad;
    assign accept = wcc_valid & wcc_ready;
    assign bad    = opcode != OPCODE_WR || len > MAX_LEN;
    assign busy   = state != IDLE;
    always_comb begin
        state_nxt = state;
        ff_rd_en  = 1'b0;
        pkt_done  = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                // no pop while reset is held, even though state already reads IDLE
                ff_rd_en  = !ff_empty && !reset;
                state_nxt = ff_empty ? IDLE : CHK;
            end
            CHK: begin
                state_nxt = bad ? DROP : len == 16'd0 ? IDLE : DATA;
                pkt_done  = !bad && len == 16'd0;
            end
            DATA: begin
                load      = !ff_empty && (!wcc_valid || wcc_ready) && pop_cnt < len;
                ff_rd_en  = load;
                // the beat carrying length 1 is the last one; nothing can be loaded behind it
                pkt_done  = accept && wcc_length == 16'd1;
                state_nxt = pkt_done ? IDLE : DATA;
            end
            DROP: begin
                ff_rd_en  = !ff_empty && pop_cnt != len;
                state_nxt = pop_cnt == len ? IDLE : DROP;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge fpu_clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge fpu_clk or posedge reset) begin
        if (reset) begin
            {opcode, len, dpram_base, dram_base} <= '0;
            pop_cnt        <= '0;
            bad_pkt_cnt    <= '0;
            wcc_dram_addr  <= '0;
            wcc_dpram_addr <= '0;
            wcc_length     <= '0;
            wcc_write_data <= '0;
            wcc_valid      <= 1'b0;
        end else begin
            if (state == IDLE && ff_rd_en) begin
                {opcode, len, dpram_base, dram_base} <= ff_rd_data[79:0];
                pop_cnt <= '0;
            end
            if (state == CHK && bad) bad_pkt_cnt <= bad_pkt_cnt + {7'd0, bad_pkt_cnt != 8'hFF};
            if (ff_rd_en && state != IDLE) pop_cnt <= pop_cnt + 16'd1;
            if (load) begin
                wcc_dram_addr  <= dram_base + 40'(pop_cnt) * 40'(ADDR_STRIDE);
                wcc_dpram_addr <= dpram_base + pop_cnt;
                wcc_length     <= len - pop_cnt;
                wcc_write_data <= ff_rd_data;
                wcc_valid      <= 1'b1;
            end else if (accept) wcc_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tsn_wcc_packer.sv
// tb_tsn_wcc_packer: directed checks of the write-command packer against hand-computed vectors
module tb_tsn_wcc_packer;
    logic         fpu_clk = 1'b0, reset = 1'b1;
    logic [127:0] ff_rd_data, wcc_write_data;
    logic         ff_empty, ff_rd_en, wcc_valid, pkt_done, busy;
    logic         wcc_ready = 1'b0;
    logic [39:0]  wcc_dram_addr;
    logic [15:0]  wcc_dpram_addr, wcc_length;
    logic [7:0]   bad_pkt_cnt;
    tsn_wcc_packer dut (
        .fpu_clk(fpu_clk), .reset(reset), .ff_rd_data(ff_rd_data), .ff_empty(ff_empty),
        .ff_rd_en(ff_rd_en), .wcc_dram_addr(wcc_dram_addr), .wcc_dpram_addr(wcc_dpram_addr),
        .wcc_length(wcc_length), .wcc_write_data(wcc_write_data), .wcc_valid(wcc_valid),
        .wcc_ready(wcc_ready), .pkt_done(pkt_done), .bad_pkt_cnt(bad_pkt_cnt), .busy(busy)
    );
    always #5 fpu_clk = ~fpu_clk;
    logic [127:0] mem [0:4095];
    int   wp = 0, rp = 0;
    logic flush = 1'b0;
    assign ff_empty   = rp == wp;
    assign ff_rd_data = mem[rp[11:0]];
    always @(posedge fpu_clk)
        if (flush) rp <= wp;
        else if (ff_rd_en && !ff_empty) rp <= rp + 1;
    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    int n_acc = 0, n_valid = 0, n_done = 0, cyc = 0, done_idx = -1, hold_err = 0, pop_err = 0;
    logic [39:0]  a_dram  [0:63];
    logic [15:0]  a_dpram [0:63];
    logic [15:0]  a_len   [0:63];
    logic [127:0] a_data  [0:63];
    int           a_cyc   [0:63];
    logic         held = 1'b0;
    logic [199:0] held_v = '0;
    always @(negedge fpu_clk) begin
        cyc++;
        if (held && !reset && (!wcc_valid || {wcc_dram_addr, wcc_dpram_addr, wcc_length, wcc_write_data} != held_v))
            hold_err++;
        held   = wcc_valid && !wcc_ready;
        held_v = {wcc_dram_addr, wcc_dpram_addr, wcc_length, wcc_write_data};
        if (ff_rd_en && (ff_empty || held)) pop_err++;
        if (wcc_valid) n_valid++;
        if (pkt_done) n_done++;
        if (wcc_valid && wcc_ready) begin
            a_dram[n_acc[5:0]]  = wcc_dram_addr;
            a_dpram[n_acc[5:0]] = wcc_dpram_addr;
            a_len[n_acc[5:0]]   = wcc_length;
            a_data[n_acc[5:0]]  = wcc_write_data;
            a_cyc[n_acc[5:0]]   = cyc;
            if (pkt_done) done_idx = n_acc;
            n_acc++;
        end
    end
    task automatic step();
        @(posedge fpu_clk);
        #1;
    endtask
    task automatic push(input logic [127:0] w);
        mem[wp[11:0]] = w;
        wp++;
    endtask
    function automatic logic [127:0] hdr(input logic [39:0] dram, input logic [15:0] dpram,
                                         input logic [15:0] len, input logic [7:0] op);
        return {48'hA5A5_0000_5A5A, op, len, dpram, dram};
    endfunction
    function automatic logic [127:0] beat(input int k);
        return {64'hBEEF_CAFE_0000_0000, 64'(k)};
    endfunction
    task automatic pkt(input logic [127:0] h, input int n, input int k0);
        push(h);
        for (int k = 0; k < n; k++) push(beat(k0 + k));
    endtask
    task automatic drain();
        int t = 0;
        while ((rp != wp || busy || wcc_valid) && t < 3000) begin
            step();
            t++;
        end
        if (t >= 3000) chk("drain_timeout", 128'(t), 128'(0));
    endtask
    logic [5:0] pat = 6'b110100;
    int b, v0, d0, t;
    initial begin
        step();
        step();
        chk("rst_valid", 128'(wcc_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_bad", 128'(bad_pkt_cnt), 128'(0));
        chk("rst_fields", {wcc_dram_addr, wcc_dpram_addr, wcc_length}, 128'(0));
        pkt(hdr(40'h00_0000_1000, 16'h0010, 16'd3, 8'h01), 3, 0);
        #1;
        chk("rst_no_pop", 128'(ff_rd_en), 128'(0));
        b = n_acc;
        d0 = n_done;
        wcc_ready = 1'b1;
        step();
        reset = 1'b0;
        drain();
        chk("basic_n", 128'(n_acc - b), 128'(3));
        chk("basic_dram0", 128'(a_dram[b]), 128'h1000);
        chk("basic_dram1", 128'(a_dram[b+1]), 128'h1010);
        chk("basic_dram2", 128'(a_dram[b+2]), 128'h1020);
        chk("basic_dpram", {a_dpram[b], a_dpram[b+1], a_dpram[b+2]}, 128'h0010_0011_0012);
        chk("basic_len", {a_len[b], a_len[b+1], a_len[b+2]}, 128'h0003_0002_0001);
        chk("basic_data", a_data[b+1], beat(1));
        chk("basic_b2b", 128'(a_cyc[b+2] - a_cyc[b]), 128'(2));
        chk("basic_done_n", 128'(n_done - d0), 128'(1));
        chk("basic_done_at", 128'(done_idx), 128'(b + 2));
        b = n_acc;
        wcc_ready = 1'b0;
        pkt(hdr(40'h00_0000_1000, 16'h0010, 16'd3, 8'h01), 3, 10);
        t = 0;
        while (!wcc_valid && t < 100) begin
            step();
            t++;
        end
        chk("bp_valid", 128'(wcc_valid), 128'(1));
        for (int i = 0; i < 6; i++) begin
            wcc_ready = pat[i];
            step();
        end
        wcc_ready = 1'b1;
        drain();
        chk("bp_n", 128'(n_acc - b), 128'(3));
        chk("bp_dram", {a_dram[b], a_dram[b+2]}, {48'h0, 40'h1000, 40'h1020});
        chk("bp_len", {a_len[b], a_len[b+1], a_len[b+2]}, 128'h0003_0002_0001);
        chk("bp_data", {a_data[b+2][63:0], a_data[b+1][63:0]}, {64'd12, 64'd11});
        chk("bp_hold", 128'(hold_err), 128'(0));
        chk("bp_pop", 128'(pop_err), 128'(0));
        b = n_acc;
        pkt(hdr(40'hFF_FFFF_FFF0, 16'hFFFF, 16'd2, 8'h01), 2, 20);
        drain();
        chk("wrap_n", 128'(n_acc - b), 128'(2));
        chk("wrap_dram0", 128'(a_dram[b]), 128'hFF_FFFF_FFF0);
        chk("wrap_dram1", 128'(a_dram[b+1]), 128'h0);
        chk("wrap_dpram", {a_dpram[b], a_dpram[b+1]}, 128'hFFFF_0000);
        b = n_acc;
        v0 = n_valid;
        pkt(hdr(40'h00_0000_3000, 16'h0100, 16'd4, 8'h02), 4, 30);
        pkt(hdr(40'h00_0000_4000, 16'h0200, 16'd1, 8'h01), 1, 40);
        drain();
        chk("badop_cnt", 128'(bad_pkt_cnt), 128'(1));
        chk("badop_n", 128'(n_acc - b), 128'(1));
        chk("badop_valid", 128'(n_valid - v0), 128'(1));
        chk("badop_good", {a_dram[b], a_dpram[b], a_len[b]}, {56'h0, 40'h4000, 16'h0200, 16'h1});
        chk("badop_data", a_data[b], beat(40));
        v0 = n_valid;
        d0 = n_done;
        push(hdr(40'h00_0000_5000, 16'h0300, 16'd0, 8'h01));
        drain();
        chk("zero_done", 128'(n_done - d0), 128'(1));
        chk("zero_valid", 128'(n_valid - v0), 128'(0));
        b = n_acc;
        pkt(hdr(40'h00_0000_6000, 16'h0400, 16'd1025, 8'h01), 1025, 100);
        pkt(hdr(40'h00_0000_0ABC, 16'h0500, 16'd1, 8'h01), 1, 50);
        drain();
        chk("max_cnt", 128'(bad_pkt_cnt), 128'(2));
        chk("max_n", 128'(n_acc - b), 128'(1));
        chk("max_good", {a_dram[b], a_dpram[b]}, {72'h0, 40'h0ABC, 16'h0500});
        b = n_acc;
        d0 = n_done;
        pkt(hdr(40'h00_0000_7000, 16'h0600, 16'd5, 8'h01), 5, 60);
        t = 0;
        while (n_acc - b < 2 && t < 100) begin
            step();
            t++;
        end
        chk("rmid_two", 128'(n_acc - b), 128'(2));
        reset = 1'b1;
        flush = 1'b1;
        #1;
        chk("rmid_valid", 128'(wcc_valid), 128'(0));
        chk("rmid_busy", 128'(busy), 128'(0));
        chk("rmid_fields", {wcc_dram_addr, wcc_dpram_addr, wcc_length}, 128'(0));
        chk("rmid_bad", 128'(bad_pkt_cnt), 128'(0));
        step();
        step();
        flush = 1'b0;
        reset = 1'b0;
        chk("rmid_stop", 128'(n_acc - b), 128'(2));
        b = n_acc;
        pkt(hdr(40'h00_0000_2000, 16'h0005, 16'd2, 8'h01), 2, 70);
        drain();
        chk("post_n", 128'(n_acc - b), 128'(2));
        chk("post_dram", {a_dram[b], a_dram[b+1]}, {48'h0, 40'h2000, 40'h2010});
        chk("post_dpram", {a_dpram[b], a_dpram[b+1]}, 128'h0005_0006);
        chk("post_len", {a_len[b], a_len[b+1]}, 128'h0002_0001);
        chk("post_done", 128'(n_done - d0), 128'(1));
        chk("end_hold", 128'(hold_err), 128'(0));
        chk("end_pop", 128'(pop_err), 128'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tsn_wcc_packer.md
Name: tsn_wcc_packer

Overview:
- Write-command packer directly downstream of the DGCL FPU write FIFO (128-bit, first-word-fall-through).
- Pops one header beat, then N data beats, and issues one 128-bit write command per data beat on the wcc_* valid/ready interface.
- Generates an incrementing DRAM address and DPRAM address for each beat.
- Discards packets whose opcode it does not recognise, and counts them.

Parameters:
- OPCODE_WR, 8'h01, header opcode for a DRAM write packet.
- ADDR_STRIDE, 16, DRAM byte-address increment per data beat.
- MAX_LEN, 16'd1024, largest legal beat count; a larger header length is treated as a bad packet.

Ports:
- fpu_clk  input  1  single block clock.
- reset  input  1  asynchronous active-high reset.
- ff_rd_data  input  128  FIFO head word (FWFT, valid while ff_empty=0).
- ff_empty  input  1  FIFO empty.
- ff_rd_en  output  1  FIFO pop, combinational, one word per cycle when high.
- wcc_dram_addr  output  40  DRAM byte address of the current beat.
- wcc_dpram_addr  output  16  DPRAM word address of the current beat.
- wcc_length  output  16  beats remaining, including the current one.
- wcc_write_data  output  128  beat payload.
- wcc_valid  output  1  command valid.
- wcc_ready  input  1  command accepted when high together with wcc_valid.
- pkt_done  output  1  one-cycle pulse when a good packet's last beat is accepted.
- bad_pkt_cnt  output  8  saturating count of dropped packets.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock (fpu_clk); reset is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Reset mid-packet: the packet is abandoned; no further commands are issued for it.
- Header fields:
  - [39:0] DRAM base address.
  - [55:40] DPRAM base address.
  - [71:56] length in beats.
  - [79:72] opcode.
  - [127:80] ignored.

State machine:
- IDLE:
  - Pop the header when ff_empty=0.
  - Latch base addresses, length and opcode; go to CHK.
- CHK (one cycle):
  - opcode≠OPCODE_WR or length>MAX_LEN → DROP; bad_pkt_cnt increments, saturating at 255.
  - length=0 → IDLE; pkt_done pulses this cycle; no command is issued.
  - Otherwise → DATA, with beat index i=0 and remaining=length.
- DATA:
  - Output stage is one register.
  - Load condition: ff_empty=0, AND (wcc_valid=0 OR wcc_ready=1), AND remaining-to-pop>0.
  - On load: ff_rd_en=1; register the beat with wcc_dram_addr=base+i*ADDR_STRIDE, wcc_dpram_addr=base+i, and wcc_length=remaining-i.
  - Address arithmetic: DRAM address is modulo 2^40; DPRAM address is modulo 2^16. Wrap is silent.
  - Latency: a beat at the FIFO head in cycle N appears with wcc_valid=1 in cycle N+1.
  - Full throughput is 1 beat/cycle while wcc_ready=1.
  - wcc_valid, once high, stays high and all wcc_* fields stay stable until wcc_ready=1.
  - A FIFO underrun mid-packet only stalls; wcc_valid drops after the held beat is accepted.
  - When the last beat is accepted and nothing more is loaded: pkt_done pulses in that cycle; wcc_valid=0 next cycle; state → IDLE.
  - The next header is not popped in the same cycle as the last beat is accepted; it is popped no earlier than the following cycle.
- DROP:
  - Pop and discard length beats, one per cycle while ff_empty=0, then → IDLE.
  - No wcc_valid and no pkt_done.
  - A length>MAX_LEN packet still discards exactly length beats.
- Register and control rules:
  - ff_rd_en is never high while ff_empty=1.
  - ff_rd_en is never high in CHK.
  - busy=1 in CHK, DATA and DROP.

Test Plan:
- Basic write: header dram=0x00_0000_1000, dpram=0x0010, len=3, op=0x01, then 3 beats; wcc_ready=1 → three commands with addresses 0x1000/0x1010/0x1020, dpram 0x10/0x11/0x12, lengths 3/2/1, back-to-back; pkt_done on the third acceptance.
- Backpressure: same packet, wcc_ready toggling 0,0,1,0,1,1 → each beat is held stable while ready=0; exactly 3 acceptances; FIFO is never popped while the output is held and not accepted.
- Wrap: dram=0xFF_FFFF_FFF0, dpram=0xFFFF, len=2 → addresses 0xFF_FFFF_FFF0 then 0x00_0000_0000; dpram 0xFFFF then 0x0000.
- Bad opcode: op=0x02, len=4, then a good len=1 packet → the first packet's 4 beats are dropped with no wcc_valid; bad_pkt_cnt=1; the good packet is issued normally.
- Zero length and MAX_LEN: len=0 → pkt_done pulses with no wcc_valid; len=1025 → that packet's 1025 beats are discarded; bad_pkt_cnt increments.
- Reset mid-packet: assert reset after the 2nd of 5 beats → all outputs 0 immediately; the next header after reset is parsed correctly.
